// File: rtl/traffic_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_sequencer
// Function : Timed phase sequencer for a two-street intersection (A / B).
//            Owns a clock prescaler and a per-phase second counter, holds
//            latched pedestrian requests, and applies emergency preemption.
//            Lamp outputs and the phase code are registered.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_phase_sequencer #(
    parameter int CLK_PER_SEC = 50000000,
    parameter int T_GREEN_MIN = 10,
    parameter int T_GREEN_MAX = 30,
    parameter int T_YELLOW    = 3,
    parameter int T_ALLRED    = 1,
    parameter int T_PED       = 8,
    parameter int TW          = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sa,
    input  logic       sb,
    input  logic       pa_req,
    input  logic       pb_req,
    input  logic       emg,
    input  logic       emg_dir,
    output logic [2:0] lamp_a,
    output logic [2:0] lamp_b,
    output logic       walk_a,
    output logic       walk_b,
    output logic       ped_wait_a,
    output logic       ped_wait_b,
    output logic [2:0] phase,
    output logic       sec_tick
);

    // Phase encoding (visible on the phase output)
    localparam logic [2:0] S_A_GREEN   = 3'd0;
    localparam logic [2:0] S_A_YELLOW  = 3'd1;
    localparam logic [2:0] S_ALLRED_AB = 3'd2;
    localparam logic [2:0] S_B_GREEN   = 3'd3;
    localparam logic [2:0] S_B_YELLOW  = 3'd4;
    localparam logic [2:0] S_ALLRED_BA = 3'd5;

    // Lamp codes {red, yellow, green}
    localparam logic [2:0] c_RED    = 3'b100;
    localparam logic [2:0] c_YELLOW = 3'b010;
    localparam logic [2:0] c_GREEN  = 3'b001;

    // Prescaler width; at least one bit even for a degenerate 1-cycle second
    localparam int c_PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(CLK_PER_SEC - 1);

    // A phase of T seconds ends on the tick where secs reaches T-1; the
    // greens compare with >= because they may rest far past their limit.
    localparam logic [TW-1:0] c_MIN_LAST = TW'(T_GREEN_MIN - 1);
    localparam logic [TW-1:0] c_MAX_LAST = TW'(T_GREEN_MAX - 1);
    localparam logic [TW-1:0] c_YEL_LAST = TW'(T_YELLOW - 1);
    localparam logic [TW-1:0] c_AR_LAST  = TW'(T_ALLRED - 1);
    localparam logic [TW-1:0] c_PED      = TW'(T_PED);
    localparam logic [TW-1:0] c_SECS_SAT = {TW{1'b1}};

    logic [2:0]      r_state;
    logic [c_PW-1:0] r_presc;
    logic [TW-1:0]   r_secs;
    logic            r_ped_wait_a;
    logic            r_ped_wait_b;

    logic [2:0]      w_state_nxt;
    logic            w_tick;
    logic            w_change;
    logic            w_walk_a;
    logic            w_walk_b;
    logic            w_demand_a;
    logic            w_demand_b;

    // Lamp pair {lamp_a, lamp_b} shown in a given phase
    function automatic logic [5:0] f_lamps(input logic [2:0] s);
        logic [5:0] l;
        case (s)
            S_A_GREEN:  l = {c_GREEN,  c_RED};
            S_A_YELLOW: l = {c_YELLOW, c_RED};
            S_B_GREEN:  l = {c_RED,    c_GREEN};
            S_B_YELLOW: l = {c_RED,    c_YELLOW};
            default:    l = {c_RED,    c_RED};
        endcase
        return l;
    endfunction

    assign w_tick     = (r_presc == c_PRESC_LAST);
    assign w_demand_a = sa | r_ped_wait_b;
    assign w_demand_b = sb | r_ped_wait_a;
    assign w_change   = (w_state_nxt != r_state);

    // Walk lamps follow the live preempt input so they drop immediately
    always_comb begin
        w_walk_a = (r_state == S_B_GREEN) && (r_secs < c_PED) && !emg;
        w_walk_b = (r_state == S_A_GREEN) && (r_secs < c_PED) && !emg;
    end

    // Next-phase decision: timed clearance, demand-driven greens, preemption
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_A_GREEN: begin
                if (emg) begin
                    if (emg_dir) w_state_nxt = S_A_YELLOW;
                end else if (w_tick && w_demand_b &&
                             ((!sa && (r_secs >= c_MIN_LAST)) || (r_secs >= c_MAX_LAST))) begin
                    w_state_nxt = S_A_YELLOW;
                end
            end
            S_A_YELLOW: begin
                if (w_tick && (r_secs >= c_YEL_LAST)) w_state_nxt = S_ALLRED_AB;
            end
            S_ALLRED_AB: begin
                if (w_tick && (r_secs >= c_AR_LAST))
                    w_state_nxt = (emg && !emg_dir) ? S_A_GREEN : S_B_GREEN;
            end
            S_B_GREEN: begin
                if (emg) begin
                    if (!emg_dir) w_state_nxt = S_B_YELLOW;
                end else if (w_tick && w_demand_a &&
                             ((!sb && (r_secs >= c_MIN_LAST)) || (r_secs >= c_MAX_LAST))) begin
                    w_state_nxt = S_B_YELLOW;
                end
            end
            S_B_YELLOW: begin
                if (w_tick && (r_secs >= c_YEL_LAST)) w_state_nxt = S_ALLRED_BA;
            end
            S_ALLRED_BA: begin
                if (w_tick && (r_secs >= c_AR_LAST))
                    w_state_nxt = (emg && emg_dir) ? S_B_GREEN : S_A_GREEN;
            end
            default: w_state_nxt = S_ALLRED_BA;
        endcase
    end

    // Phase register, timebase, pedestrian latches and registered lamps
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_ALLRED_BA;
            r_presc      <= '0;
            r_secs       <= '0;
            r_ped_wait_a <= 1'b0;
            r_ped_wait_b <= 1'b0;
            lamp_a       <= c_RED;
            lamp_b       <= c_RED;
        end else begin
            r_state <= w_state_nxt;

            if (w_change) begin
                r_presc <= '0;
                r_secs  <= '0;
            end else if (w_tick) begin
                r_presc <= '0;
                if (r_secs != c_SECS_SAT) r_secs <= r_secs + TW'(1);
            end else begin
                r_presc <= r_presc + c_PW'(1);
            end

            // Entering the serving green wins over a simultaneous new press
            if (w_change && (w_state_nxt == S_B_GREEN))
                r_ped_wait_a <= 1'b0;
            else if (pa_req && !w_walk_a)
                r_ped_wait_a <= 1'b1;

            if (w_change && (w_state_nxt == S_A_GREEN))
                r_ped_wait_b <= 1'b0;
            else if (pb_req && !w_walk_b)
                r_ped_wait_b <= 1'b1;

            {lamp_a, lamp_b} <= f_lamps(w_state_nxt);
        end
    end

    assign phase      = r_state;
    assign sec_tick   = w_tick;
    assign walk_a     = w_walk_a;
    assign walk_b     = w_walk_b;
    assign ped_wait_a = r_ped_wait_a;
    assign ped_wait_b = r_ped_wait_b;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_phase_sequencer
// Function : Self-checking bench for traffic_phase_sequencer. A cycle-level
//            model tracks phase and time-in-phase and is compared on every
//            falling edge; directed scenarios add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_sequencer;

    localparam int CPS  = 4;
    localparam int GMIN = 3;
    localparam int GMAX = 6;
    localparam int YEL  = 2;
    localparam int AR   = 1;
    localparam int PED  = 2;
    localparam int TW   = 6;
    localparam int SAT  = (1 << TW) - 1;

    localparam int P_AG = 0, P_AY = 1, P_ARAB = 2, P_BG = 3, P_BY = 4, P_ARBA = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sa = 1'b0, sb = 1'b0, pa_req = 1'b0, pb_req = 1'b0;
    logic       emg = 1'b0, emg_dir = 1'b0;
    logic [2:0] lamp_a, lamp_b, phase;
    logic       walk_a, walk_b, ped_wait_a, ped_wait_b, sec_tick;

    always #5 clk = ~clk;

    traffic_phase_sequencer #(
        .CLK_PER_SEC(CPS), .T_GREEN_MIN(GMIN), .T_GREEN_MAX(GMAX),
        .T_YELLOW(YEL), .T_ALLRED(AR), .T_PED(PED), .TW(TW)
    ) dut (
        .clk(clk), .reset(reset), .sa(sa), .sb(sb),
        .pa_req(pa_req), .pb_req(pb_req), .emg(emg), .emg_dir(emg_dir),
        .lamp_a(lamp_a), .lamp_b(lamp_b), .walk_a(walk_a), .walk_b(walk_b),
        .ped_wait_a(ped_wait_a), .ped_wait_b(ped_wait_b),
        .phase(phase), .sec_tick(sec_tick)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_ph;
    int m_cyc;
    bit m_pwa, m_pwb;
    int m_nx;
    bit m_new_a, m_new_b;
    int lamp_a_tab [6] = '{1, 2, 4, 4, 4, 4};
    int lamp_b_tab [6] = '{4, 4, 4, 1, 2, 4};

    function automatic int m_secs();
        int s;
        s = m_cyc / CPS;
        return (s > SAT) ? SAT : s;
    endfunction

    function automatic bit m_tick();
        return (m_cyc % CPS) == CPS - 1;
    endfunction

    function automatic bit m_walk_a();
        return (m_ph == P_BG) && (m_secs() < PED) && !emg;
    endfunction

    function automatic bit m_walk_b();
        return (m_ph == P_AG) && (m_secs() < PED) && !emg;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ph = P_ARBA; m_cyc = 0; m_pwa = 0; m_pwb = 0;
        end else begin
            m_nx = m_ph;
            // seconds completed at this boundary: m_secs()+1
            case (m_ph)
                P_AG: if (emg) begin
                          if (emg_dir) m_nx = P_AY;
                      end else if (m_tick() && (sb || m_pwa) && (m_secs() + 1 >= (sa ? GMAX : GMIN)))
                          m_nx = P_AY;
                P_BG: if (emg) begin
                          if (!emg_dir) m_nx = P_BY;
                      end else if (m_tick() && (sa || m_pwb) && (m_secs() + 1 >= (sb ? GMAX : GMIN)))
                          m_nx = P_BY;
                P_AY:   if (m_tick() && m_secs() + 1 >= YEL) m_nx = P_ARAB;
                P_BY:   if (m_tick() && m_secs() + 1 >= YEL) m_nx = P_ARBA;
                P_ARAB: if (m_tick() && m_secs() + 1 >= AR) m_nx = (emg && !emg_dir) ? P_AG : P_BG;
                P_ARBA: if (m_tick() && m_secs() + 1 >= AR) m_nx = (emg && emg_dir) ? P_BG : P_AG;
                default: m_nx = P_ARBA;
            endcase
            m_new_a = m_pwa | (pa_req && !m_walk_a());
            m_new_b = m_pwb | (pb_req && !m_walk_b());
            if (m_nx == P_BG && m_ph != P_BG) m_new_a = 0;
            if (m_nx == P_AG && m_ph != P_AG) m_new_b = 0;
            m_pwa = m_new_a;
            m_pwb = m_new_b;
            m_cyc = (m_nx != m_ph) ? 0 : m_cyc + 1;
            m_ph  = m_nx;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        check("phase",      phase,      m_ph);
        check("lamp_a",     lamp_a,     lamp_a_tab[m_ph]);
        check("lamp_b",     lamp_b,     lamp_b_tab[m_ph]);
        check("walk_a",     walk_a,     m_walk_a());
        check("walk_b",     walk_b,     m_walk_b());
        check("ped_wait_a", ped_wait_a, m_pwa);
        check("ped_wait_b", ped_wait_b, m_pwb);
        check("sec_tick",   sec_tick,   reset && m_tick());
    end

    // ---------------- directed scenarios ----------------
    int cur;

    task automatic goto(input int c);
        repeat (c - cur) @(negedge clk);
        cur = c;
    endtask

    task automatic start(input bit a, input bit b);
        @(negedge clk);
        #2;
        reset = 1'b0;
        {pa_req, pb_req, emg, emg_dir} = 4'b0;
        sa = a;
        sb = b;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        cur = 0;
    endtask

    initial begin
        // 1: idle intersection rests in A_GREEN
        start(0, 0);
        goto(0);   check("s1 reset phase", phase, 5); check("s1 reset lamp_a", lamp_a, 3'b100);
        goto(3);   check("s1 c3 phase", phase, 5); check("s1 c3 sec_tick", sec_tick, 1);
        goto(4);   check("s1 c4 phase", phase, 0); check("s1 c4 lamp_a", lamp_a, 3'b001);
        goto(11);  check("s1 c11 walk_b", walk_b, 1);
        goto(12);  check("s1 c12 walk_b", walk_b, 0);
        goto(200); check("s1 c200 phase", phase, 0);

        // 2: side-street car, min green
        start(0, 1);
        goto(15); check("s2 c15 phase", phase, 0);
        goto(16); check("s2 c16 phase", phase, 1); check("s2 c16 lamp_a", lamp_a, 3'b010);
        goto(24); check("s2 c24 phase", phase, 2);
        goto(28); check("s2 c28 phase", phase, 3); check("s2 c28 lamp_b", lamp_b, 3'b001);

        // 3: both streets loaded, max greens
        start(1, 1);
        goto(27); check("s3 c27 phase", phase, 0);
        goto(28); check("s3 c28 phase", phase, 1);
        goto(40); check("s3 c40 phase", phase, 3);
        goto(63); check("s3 c63 phase", phase, 3);
        goto(64); check("s3 c64 phase", phase, 4);
        goto(76); check("s3 c76 phase", phase, 0);

        // 4: pedestrian requests
        start(0, 0);
        goto(6);  #2 pb_req = 1'b1;
        goto(7);  check("s4 pb ignored", ped_wait_b, 0); #2 pb_req = 1'b0;
        goto(24); check("s4 c24 wait_a", ped_wait_a, 0); #2 pa_req = 1'b1;
        goto(25); check("s4 c25 wait_a", ped_wait_a, 1); #2 pa_req = 1'b0;
        goto(27); check("s4 c27 phase", phase, 0);
        goto(28); check("s4 c28 phase", phase, 1);
        goto(39); check("s4 c39 wait_a", ped_wait_a, 1);
        goto(40); check("s4 c40 phase", phase, 3); check("s4 c40 wait_a", ped_wait_a, 0);
                  check("s4 c40 walk_a", walk_a, 1);
        goto(47); check("s4 c47 walk_a", walk_a, 1);
        goto(48); check("s4 c48 walk_a", walk_a, 0);

        // 5: emergency preempt toward B
        start(0, 0);
        goto(9);  check("s5 c9 walk_b pre", walk_b, 1);
        #2 emg = 1'b1; emg_dir = 1'b1; sa = 1'b1; sb = 1'b1;
        #1 check("s5 c9 walk_b emg", walk_b, 0);
        goto(10); check("s5 c10 phase", phase, 1);
        goto(21); check("s5 c21 phase", phase, 2);
        goto(22); check("s5 c22 phase", phase, 3); check("s5 c22 walk_a", walk_a, 0);
        goto(80); check("s5 c80 phase", phase, 3); #2 emg = 1'b0;
        goto(81); check("s5 c81 phase", phase, 3);
        goto(82); check("s5 c82 phase", phase, 4);

        // 6: asynchronous reset in A_YELLOW
        start(0, 1);
        goto(17); check("s6 c17 phase", phase, 1); #2 pb_req = 1'b1;
        goto(18); check("s6 c18 wait_b", ped_wait_b, 1);
        #2 pb_req = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("s6 rst phase",  phase, 5);
        check("s6 rst lamp_a", lamp_a, 3'b100);
        check("s6 rst lamp_b", lamp_b, 3'b100);
        check("s6 rst wait_b", ped_wait_b, 0);
        check("s6 rst wait_a", ped_wait_a, 0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
